uart_send: RTL and testbench

Transmit-only UART serializer. Accepts a byte on a one-cycle `DATA_READY` strobe and shifts it out on `TXD` as an asynchronous serial frame: start bit, `DATA_BITS` data bits LSB first, one stop bit. Bit timing comes from an external baud-tick strobe `UART_CLK`. The block sits between the capture/stream logic and the board's TX pin, and it reports readiness for the next byte on `IDLE`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_send.sv | 115 +++++++++++
 tb/tb_uart_send.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit types and constants.
// Parity framing is enabled by defining UART_SEND_PARITY_EN.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam logic TXD_IDLE = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

endpackage

// File: rtl/uart_send.sv
// Transmit-only UART serializer paced by an external baud tick.
// Define UART_SEND_PARITY_EN for an even-parity bit before the stop bit.
module uart_send
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UART_CLK,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 DATA_READY,
  output logic                 TXD,
  output logic                 IDLE
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  state_t               state;
  logic                 pending;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] next_byte;
  logic [CW-1:0]        cnt;
  logic                 txd;
  logic                 load;
`ifdef UART_SEND_PARITY_EN
  logic                 par;
`endif

  assign IDLE = ((state == S_IDLE) || (state == S_STOP)) && !pending;
  assign load = DATA_READY && IDLE;
  assign TXD  = txd;

  // A byte loaded in the stop-bit cycle goes straight to the shifter.
  assign next_byte = pending ? hold : DATA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      hold    <= '0;
      shreg   <= '0;
      cnt     <= '0;
      txd     <= TXD_IDLE;
`ifdef UART_SEND_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      if (load) begin
        hold    <= DATA;
        pending <= 1'b1;
      end
      if (UART_CLK) begin
        unique case (state)
          S_IDLE: begin
            if (pending) begin
              state   <= S_START;
              txd     <= 1'b0;
              shreg   <= hold;
              pending <= 1'b0;
`ifdef UART_SEND_PARITY_EN
              par     <= ^hold;
`endif
            end
          end
          S_START: begin
            state <= S_DATA;
            cnt   <= '0;
            txd   <= shreg[0];
          end
          S_DATA: begin
            if (cnt == LAST) begin
`ifdef UART_SEND_PARITY_EN
              state <= S_PARITY;
              txd   <= par;
`else
              state <= S_STOP;
              txd   <= TXD_IDLE;
`endif
            end else begin
              cnt   <= cnt + CW'(1);
              shreg <= shreg >> 1;
              txd   <= shreg[1];
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            txd   <= TXD_IDLE;
          end
          S_STOP: begin
            if (pending || load) begin
              state   <= S_START;
              txd     <= 1'b0;
              shreg   <= next_byte;
              pending <= 1'b0;
`ifdef UART_SEND_PARITY_EN
              par     <= ^next_byte;
`endif
            end else begin
              state <= S_IDLE;
              txd   <= TXD_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
            txd   <= TXD_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Scoreboard bench for uart_send: expected line bits queued per load,
// checked against TXD every clock by an independent monitor.
module tb_uart_send;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UART_CLK = 1'b0;
  logic [7:0] DATA = '0;
  logic       DATA_READY = 1'b0;
  logic       TXD;
  logic       IDLE;

  typedef struct {
    logic b;
    int   c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   tphase = 0;
  logic exp_line = 1'b1;

  uart_send #(.DATA_BITS(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .UART_CLK  (UART_CLK),
    .DATA      (DATA),
    .DATA_READY(DATA_READY),
    .TXD       (TXD),
    .IDLE      (IDLE)
  );

  always #5 CLK = ~CLK;

  // One-cycle tick every 5 clocks, changed away from both edges.
  always @(posedge CLK) begin
    #2;
    tphase = (tphase == 4) ? 0 : tphase + 1;
    UART_CLK = (tphase == 4);
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: line model advances only on ticks after the load edge.
  always @(posedge CLK) begin
    logic t, r;
    cyc++;
    t = UART_CLK;
    r = RST;
    #1;
    if (r) begin
      exp_line = 1'b1;
      chk("idle_in_reset", IDLE, 1'b1);
    end else if (t) begin
      if (q.size() > 0 && q[0].c < cyc) begin
        exp_line = q[0].b;
        void'(q.pop_front());
      end else begin
        exp_line = 1'b1;
      end
    end
    chk("txd", TXD, exp_line);
  end

  task automatic push_frame(input logic [7:0] b, input int lc);
    exp_t e;
    e.c = lc;
    e.b = 1'b0;
    q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.b = b[i];
      q.push_back(e);
    end
`ifdef UART_SEND_PARITY_EN
    e.b = ^b;
    q.push_back(e);
`endif
    e.b = 1'b1;
    q.push_back(e);
  endtask

  // Called at a negedge; load edge is the next posedge.
  task automatic send(input logic [7:0] b);
    DATA = b;
    DATA_READY = 1'b1;
    push_frame(b, cyc + 1);
    @(negedge CLK);
    DATA_READY = 1'b0;
    DATA = 'x;
  endtask

  task automatic wait_size(input int n, input int budget);
    int k = 0;
    while (q.size() > n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    n_chk++;
    if (q.size() > n) begin
      n_fail++;
      $display("FAIL wait_size: queue %0d required <= %0d", q.size(), n);
    end
  endtask

  task automatic wait_tick_next();
    int k = 0;
    while (!UART_CLK && k < 10) begin
      @(negedge CLK);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 10 cycles with ticks running.
    repeat (10) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_after_reset", IDLE, 1'b1);

    // Single byte 0xAA.
    send(8'hAA);
    chk("idle_low_after_load", IDLE, 1'b0);
    wait_size(0, 200);
    chk("idle_at_stop", IDLE, 1'b1);

    // Load 0x4C during the 0xAA stop bit.
    send(8'h4C);
    chk("idle_low_stop_load", IDLE, 1'b0);
    wait_size(6, 200);
    chk("idle_low_mid_frame", IDLE, 1'b0);

    // Ignored request mid-frame.
    DATA = 8'hFF;
    DATA_READY = 1'b1;
    @(negedge CLK);
    DATA_READY = 1'b0;
    DATA = 'x;
    wait_size(1, 200);
    chk("idle_low_before_stop", IDLE, 1'b0);
    wait_size(0, 200);
    chk("idle_at_stop_4c", IDLE, 1'b1);
    repeat (15) @(negedge CLK);
    chk("idle_after_4c", IDLE, 1'b1);

    // Request held for 2 cycles loads once.
    DATA = 8'h55;
    DATA_READY = 1'b1;
    push_frame(8'h55, cyc + 1);
    repeat (2) @(negedge CLK);
    DATA_READY = 1'b0;
    DATA = 'x;
    chk("idle_low_held", IDLE, 1'b0);
    wait_size(0, 200);
    repeat (15) @(negedge CLK);

    // Load on the same edge as a tick: start waits for next tick.
    wait_tick_next();
    send(8'h0F);
    wait_size(0, 200);
    repeat (12) @(negedge CLK);

    // Abort during data bit 3.
    send(8'hC3);
    wait_size(5, 200);
    RST = 1'b1;
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
    chk("idle_after_abort", IDLE, 1'b1);
    repeat (15) @(negedge CLK);

    // Pending byte discarded by reset before its start tick.
    wait_tick_next();
    @(negedge CLK);
    send(8'h81);
    chk("idle_low_pending", IDLE, 1'b0);
    RST = 1'b1;
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
    chk("idle_after_discard", IDLE, 1'b1);
    repeat (20) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
